multi_sync_debounce: RTL and testbench



---
 rtl/multi_sync_debounce.sv | 128 ++++++++++++
 tb/tb_multi_sync_debounce.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_sync_debounce.sv
// multi_sync_debounce
//   Conditions CHANNELS asynchronous single-bit inputs for use in the clk
//   domain: each bit passes through a SYNC_STAGES-deep synchroniser chain,
//   is filtered by a per-channel stability counter and produces registered
//   one-cycle rise/fall ticks.
//
//   Build option: define MSYNC_DEBOUNCE_EN to compile in the stability
//   counters. Without it the counters are removed, DEBOUNCE_CYCLES is not
//   used for filtering and sync_out follows the synchroniser output with
//   one register of latency.
//
// Ports
//   clk            : sole clock
//   rst            : asynchronous, active-high reset
//   async_in       : [CHANNELS] unsynchronised inputs
//   sync_out       : [CHANNELS] synchronised, debounced level (registered)
//   rise_edge_tick : [CHANNELS] one-cycle pulse when sync_out[i] goes 0->1
//   fall_edge_tick : [CHANNELS] one-cycle pulse when sync_out[i] goes 1->0
//   any_edge       : OR of all rise and fall ticks (no added latency)
module multi_sync_debounce #(
  parameter int                  CHANNELS        = 4,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VAL       = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] rise_edge_tick,
  output logic [CHANNELS-1:0] fall_edge_tick,
  output logic                any_edge
);

  // Reject configurations the structure cannot support at elaboration time.
  if ((CHANNELS < 1) || (SYNC_STAGES < 2) || (DEBOUNCE_CYCLES < 1)) begin : g_bad_params
    $error("multi_sync_debounce: illegal parameter set");
  end

  logic [SYNC_STAGES-1:0] sync_chain_r [CHANNELS];
  logic [CHANNELS-1:0]    sync_bit_s;
  logic [CHANNELS-1:0]    sync_out_nxt_s;
  logic [CHANNELS-1:0]    rise_nxt_s;
  logic [CHANNELS-1:0]    fall_nxt_s;

  // Flatten the last synchroniser stage of every channel into one vector.
  always_comb begin
    sync_bit_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      sync_bit_s[i] = sync_chain_r[i][SYNC_STAGES-1];
    end
  end

`ifdef MSYNC_DEBOUNCE_EN
  localparam int                CNT_W    = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1
                                         : $clog2(DEBOUNCE_CYCLES + 1);
  // The counter value seen on the edge that completes DEBOUNCE_CYCLES
  // consecutive mismatching samples.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r     [CHANNELS];
  logic [CNT_W-1:0] cnt_nxt_s [CHANNELS];

  // Stability filter: accept a new level only after it has differed from
  // sync_out on DEBOUNCE_CYCLES consecutive edges; any match restarts it.
  always_comb begin
    sync_out_nxt_s = sync_out;
    rise_nxt_s     = {CHANNELS{1'b0}};
    fall_nxt_s     = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt_s[i] = {CNT_W{1'b0}};
      if (sync_bit_s[i] == sync_out[i]) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == CNT_LAST) begin
        sync_out_nxt_s[i] = sync_bit_s[i];
        rise_nxt_s[i]     = sync_bit_s[i];
        fall_nxt_s[i]     = ~sync_bit_s[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // Stability counter registers; reset aborts any pending change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end
`else
  // Unfiltered path: sync_out follows the synchroniser every edge and any
  // change of that register is reported as a tick.
  always_comb begin
    sync_out_nxt_s = sync_bit_s;
    rise_nxt_s     = sync_bit_s & ~sync_out;
    fall_nxt_s     = ~sync_bit_s & sync_out;
  end
`endif

  // Synchroniser chains plus the registered level and tick outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_chain_r[i] <= {SYNC_STAGES{RESET_VAL[i]}};
      end
      sync_out       <= RESET_VAL;
      rise_edge_tick <= {CHANNELS{1'b0}};
      fall_edge_tick <= {CHANNELS{1'b0}};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_chain_r[i] <= {sync_chain_r[i][SYNC_STAGES-2:0], async_in[i]};
      end
      sync_out       <= sync_out_nxt_s;
      rise_edge_tick <= rise_nxt_s;
      fall_edge_tick <= fall_nxt_s;
    end
  end

  // Combinational summary of the already-registered tick vectors.
  assign any_edge = (|rise_edge_tick) | (|fall_edge_tick);

endmodule

// File: tb/tb_multi_sync_debounce.sv
// Self-checking bench for multi_sync_debounce (CHANNELS=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, RESET_VAL=0). Expected latency follows the
// MSYNC_DEBOUNCE_EN build option.
module tb_multi_sync_debounce;

  localparam int         CH  = 4;
  localparam int         SS  = 2;
  localparam int         DEB = 4;
  localparam logic [3:0] RV  = 4'b0000;
`ifdef MSYNC_DEBOUNCE_EN
  localparam int         DEFF = DEB;
`else
  localparam int         DEFF = 1;
`endif
  localparam int         LAT = SS + DEFF;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] async_in;
  logic [3:0] sync_out, rise_edge_tick, fall_edge_tick;
  logic       any_edge;

  multi_sync_debounce #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .sync_out(sync_out),
    .rise_edge_tick(rise_edge_tick), .fall_edge_tick(fall_edge_tick),
    .any_edge(any_edge)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: sampled input history; a channel flips when the last
  // DEFF synchronised samples all differ from its current level.
  logic [3:0] samp [$];
  logic [3:0] m_out, m_rise, m_fall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      samp = {};
      for (int k = 0; k < SS + DEFF; k++) samp.push_back(RV);
      m_out  = RV;
      m_rise = 4'b0000;
      m_fall = 4'b0000;
    end else begin
      samp.push_back(async_in);
      if (samp.size() > 64) void'(samp.pop_front());
      m_rise = 4'b0000;
      m_fall = 4'b0000;
      for (int c = 0; c < CH; c++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = 0; k < DEFF; k++)
          if (samp[samp.size() - 1 - SS - k][c] == m_out[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_out[c]  = ~m_out[c];
          m_rise[c] = m_out[c];
          m_fall[c] = ~m_out[c];
        end
      end
    end
  end

  function automatic logic [15:0] pk(input logic [3:0] o, r, f, input logic a);
    return {o, r, f, 3'b000, a};
  endfunction

  function automatic logic [15:0] dut_now();
    return pk(sync_out, rise_edge_tick, fall_edge_tick, any_edge);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else passed++;
  endtask

  task automatic settle(input logic [3:0] v, input int n);
    async_in = v;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #2;
    end
  endtask

  // Drive pattern bit k-1 on channel ch before edge k; record ticks on ch.
  task automatic run_watch(input logic [31:0] pat, input int n, input int ch,
                           output int first_rise, output int nr, output int nf);
    first_rise = 0; nr = 0; nf = 0;
    for (int k = 1; k <= n; k++) begin
      async_in[ch] = pat[k-1];
      @(posedge clk); #1;
      if (rise_edge_tick[ch]) begin
        nr++;
        if (first_rise == 0) first_rise = k;
      end
      if (fall_edge_tick[ch]) nf++;
      #1;
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] ain;
    logic [3:0] e_out;
    logic [3:0] e_rise;
    logic [3:0] e_fall;
  } vec_t;

  vec_t tbl [$];

  initial begin
    int fr, nr, nf;
    int e_fr, e_nr, e_nf;

    // Clean rise then fall on ch0, starting from reset.
    for (int k = 0; k < 2; k++)
      tbl.push_back('{rst: 1'b1, ain: 4'b0000, e_out: 4'b0000, e_rise: 4'b0000, e_fall: 4'b0000});
    for (int k = 1; k <= 10; k++)
      tbl.push_back('{rst: 1'b0, ain: 4'b0001,
                      e_out:  (k >= LAT) ? 4'b0001 : 4'b0000,
                      e_rise: (k == LAT) ? 4'b0001 : 4'b0000, e_fall: 4'b0000});
    for (int k = 1; k <= 10; k++)
      tbl.push_back('{rst: 1'b0, ain: 4'b0000,
                      e_out:  (k < LAT) ? 4'b0001 : 4'b0000, e_rise: 4'b0000,
                      e_fall: (k == LAT) ? 4'b0001 : 4'b0000});

    rst = 1'b0; async_in = 4'b0000;
    #1 rst = 1'b1;
    #1;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; async_in = tbl[i].ain;
      @(posedge clk); #1;
      chk($sformatf("table[%0d]", i), dut_now(),
          pk(tbl[i].e_out, tbl[i].e_rise, tbl[i].e_fall, |(tbl[i].e_rise | tbl[i].e_fall)));
      #1;
    end

    // Reset with input 1010, then release.
    rst = 1'b1; async_in = 4'b1010; #1;
    chk("rst1010_in_reset", dut_now(), 16'h0000);
    @(posedge clk); @(posedge clk); #1;
    chk("rst1010_held", dut_now(), 16'h0000);
    #1 rst = 1'b0;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst1010_edge%0d", k), dut_now(),
          pk((k >= LAT) ? 4'b1010 : 4'b0000, (k == LAT) ? 4'b1010 : 4'b0000,
             4'b0000, (k == LAT)));
      #1;
    end

    // Glitch: ch1 high for three cycles only.
    settle(4'b0000, 12);
    run_watch(32'h0000_0007, 12, 1, fr, nr, nf);
`ifdef MSYNC_DEBOUNCE_EN
    e_fr = 0;  e_nr = 1 - 1; e_nf = 0;
`else
    e_fr = 3;  e_nr = 1;     e_nf = 1;
`endif
    chk("glitch_first_rise", fr, e_fr);
    chk("glitch_rises", nr, e_nr);
    chk("glitch_falls", nf, e_nf);
    chk("glitch_sync_out", sync_out, 4'b0000);

    // Bounce 1,1,1,0,1,1,1,1 then steady high on ch1.
    settle(4'b0000, 8);
    run_watch(32'hFFFF_FFF7, 16, 1, fr, nr, nf);
`ifdef MSYNC_DEBOUNCE_EN
    e_fr = 10; e_nr = 1; e_nf = 0;
`else
    e_fr = 3;  e_nr = 2; e_nf = 1;
`endif
    chk("bounce_first_rise", fr, e_fr);
    chk("bounce_rises", nr, e_nr);
    chk("bounce_falls", nf, e_nf);
    chk("bounce_sync_out", sync_out, 4'b0010);

    // Simultaneous rise on ch1 and fall on ch2.
    settle(4'b0100, 12);
    chk("simul_pre", sync_out, 4'b0100);
    async_in = 4'b0010;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      chk($sformatf("simul_edge%0d", k), dut_now(),
          pk((k >= LAT) ? 4'b0010 : 4'b0100, (k == LAT) ? 4'b0010 : 4'b0000,
             (k == LAT) ? 4'b0100 : 4'b0000, (k == LAT)));
      #1;
    end

    // A tick present when reset asserts is cleared at once.
    settle(4'b0000, 12);
    async_in = 4'b0100;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #2;
    end
    chk("tick_before_rst", rise_edge_tick, 4'b0100);
    rst = 1'b1; #1;
    chk("tick_cleared_by_rst", dut_now(), 16'h0000);
    @(posedge clk); #2;
    async_in = 4'b0000; rst = 1'b0;

    // Reset while ch3 is mid-count.
    settle(4'b0001, 12);
    async_in = 4'b1001;
    for (int k = 1; k <= SS + 2; k++) begin
      @(posedge clk); #2;
    end
    rst = 1'b1; #1;
    chk("midcount_rst_clear", dut_now(), 16'h0000);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      chk($sformatf("midcount_edge%0d", k), dut_now(),
          pk((k >= LAT) ? 4'b1001 : 4'b0000, (k == LAT) ? 4'b1001 : 4'b0000,
             4'b0000, (k == LAT)));
      #1;
    end

    // Randomised run against the reference model.
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < CH; b++)
        if ($urandom_range(5) == 0) async_in[b] = ~async_in[b];
      rst = ($urandom_range(199) == 0);
      @(posedge clk); #1;
      chk($sformatf("rand[%0d]", n), dut_now(),
          pk(m_out, m_rise, m_fall, |(m_rise | m_fall)));
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
